// File: rtl/main_memory_if.sv
// ---------------------------------------------------------------------------
// main_memory_if
// Bus between the cache arbiter (master) and main_memory (slave).
//
// Signals:
//   mem_req        master -> slave  request, held high until the response is consumed
//   mem_write      master -> slave  1 = line write, 0 = line read
//   mem_addr       master -> slave  byte address (ADDRESS_WIDTH bits)
//   mem_data       master -> slave  write line data (CACHE_LINE_WIDTH bits)
//   mem_resp_valid slave -> master  transaction complete, read data valid
//   mem_resp_data  slave -> master  read line data
//   mem_busy       slave -> master  memory is not idle
//   mem_err        slave -> master  out-of-range access, qualified by mem_resp_valid
// ---------------------------------------------------------------------------
interface main_memory_if #(
  parameter int ADDRESS_WIDTH    = 32,
  parameter int CACHE_LINE_WIDTH = 128
);
  logic                        mem_req;
  logic                        mem_write;
  logic [ADDRESS_WIDTH-1:0]    mem_addr;
  logic [CACHE_LINE_WIDTH-1:0] mem_data;
  logic                        mem_resp_valid;
  logic [CACHE_LINE_WIDTH-1:0] mem_resp_data;
  logic                        mem_busy;
  logic                        mem_err;

  modport master (
    output mem_req, mem_write, mem_addr, mem_data,
    input  mem_resp_valid, mem_resp_data, mem_busy, mem_err
  );

  modport slave (
    input  mem_req, mem_write, mem_addr, mem_data,
    output mem_resp_valid, mem_resp_data, mem_busy, mem_err
  );
endinterface

// File: rtl/main_memory.sv
// ---------------------------------------------------------------------------
// main_memory
// Fixed-latency line-granular backing memory behind the cache arbiter.
// A request is accepted in IDLE, its command/index/data are latched, a
// latency counter runs in BUSY, the array is accessed when the counter has
// reached zero, and the response is held in RESP until mem_req drops.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset (array contents are not cleared)
//   bus    main_memory_if.slave (mem_req/mem_write/mem_addr/mem_data in,
//          mem_resp_valid/mem_resp_data/mem_busy/mem_err out)
//
// Parameters:
//   MEM_LATENCY      edges from the accepting edge to the edge raising
//                    mem_resp_valid (1..255)
//   MEM_DEPTH_LINES  number of stored lines (power of two, >= 2)
//
// Configuration macro:
//   MAIN_MEMORY_RANGE_CHECK_EN  when defined, addresses beyond the array are
//                               flagged with mem_err, never written and read
//                               back as zero; when undefined the index wraps
//                               and mem_err is tied low.
// ---------------------------------------------------------------------------
module main_memory #(
  parameter int ADDRESS_WIDTH    = 32,
  parameter int CACHE_LINE_WIDTH = 128,
  parameter int MEM_LATENCY      = 5,
  parameter int MEM_DEPTH_LINES  = 1024
) (
  input  logic          clk,
  input  logic          reset,
  main_memory_if.slave  bus
);

  localparam int OFF   = $clog2(CACHE_LINE_WIDTH / 8);
  localparam int IDX_W = $clog2(MEM_DEPTH_LINES);
  localparam logic [7:0] LAT_INIT = 8'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                      state;
  logic [7:0]                  count;
  logic                        wr_q;
  logic [IDX_W-1:0]            idx_q;
  logic [CACHE_LINE_WIDTH-1:0] data_q;
  logic                        resp_valid_q;
  logic [CACHE_LINE_WIDTH-1:0] resp_data_q;
  logic                        busy_q;

  logic [CACHE_LINE_WIDTH-1:0] mem_array [MEM_DEPTH_LINES];

  logic [IDX_W-1:0] addr_idx;
  logic             access_now;
  logic             array_we;
  logic             unused_addr_bits;

  assign addr_idx   = bus.mem_addr[OFF+IDX_W-1:OFF];
  assign access_now = (state == BUSY) && (count == 8'd0) && bus.mem_req;

`ifdef MAIN_MEMORY_RANGE_CHECK_EN
  logic addr_oor;
  logic oor_q;
  logic err_q;

  // Any set bit above the index field means the line number is at least
  // MEM_DEPTH_LINES, since the depth is a power of two.
  assign addr_oor         = |bus.mem_addr[ADDRESS_WIDTH-1:OFF+IDX_W];
  assign unused_addr_bits = ^bus.mem_addr[OFF-1:0];
  assign array_we         = reset && access_now && wr_q && !oor_q;
  assign bus.mem_err      = err_q;
`else
  // Upper address bits are dropped so the index wraps modulo the depth.
  assign unused_addr_bits = ^{bus.mem_addr[ADDRESS_WIDTH-1:OFF+IDX_W], bus.mem_addr[OFF-1:0]};
  assign array_we         = reset && access_now && wr_q;
  assign bus.mem_err      = 1'b0;
`endif

  assign bus.mem_resp_valid = resp_valid_q;
  assign bus.mem_resp_data  = resp_data_q;
  assign bus.mem_busy       = busy_q;

  // Array write port. Gated by reset so an edge seen while reset is held
  // low can never commit an aborted write.
  always_ff @(posedge clk) begin
    if (array_we) begin
      mem_array[idx_q] <= data_q;
    end
  end

  // Transaction FSM. Abort in BUSY takes priority over completion, so a
  // request dropped on the completing edge leaves the array untouched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      count        <= 8'd0;
      wr_q         <= 1'b0;
      idx_q        <= '0;
      data_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      busy_q       <= 1'b0;
`ifdef MAIN_MEMORY_RANGE_CHECK_EN
      oor_q        <= 1'b0;
      err_q        <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.mem_req) begin
            state  <= BUSY;
            busy_q <= 1'b1;
            wr_q   <= bus.mem_write;
            idx_q  <= addr_idx;
            data_q <= bus.mem_data;
            count  <= LAT_INIT;
`ifdef MAIN_MEMORY_RANGE_CHECK_EN
            oor_q  <= addr_oor;
`endif
          end
        end

        BUSY: begin
          if (!bus.mem_req) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            count  <= 8'd0;
          end else if (count == 8'd0) begin
            state        <= RESP;
            resp_valid_q <= 1'b1;
`ifdef MAIN_MEMORY_RANGE_CHECK_EN
            err_q        <= oor_q;
            if (!wr_q) begin
              resp_data_q <= oor_q ? '0 : mem_array[idx_q];
            end
`else
            if (!wr_q) begin
              resp_data_q <= mem_array[idx_q];
            end
`endif
          end else begin
            count <= count - 8'd1;
          end
        end

        RESP: begin
          if (!bus.mem_req) begin
            state        <= IDLE;
            busy_q       <= 1'b0;
            resp_valid_q <= 1'b0;
`ifdef MAIN_MEMORY_RANGE_CHECK_EN
            err_q        <= 1'b0;
`endif
          end
        end

        default: begin
          state        <= IDLE;
          busy_q       <= 1'b0;
          resp_valid_q <= 1'b0;
          count        <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_main_memory.sv
// ---------------------------------------------------------------------------
// tb_main_memory
// Randomised scoreboard bench for main_memory. The driver issues
// transactions and pushes the expected response; a negedge monitor pops and
// compares whenever mem_resp_valid rises. The reference is an associative
// array of lines indexed by (addr >> 4) modulo the depth.
// ---------------------------------------------------------------------------
module tb_main_memory;

  localparam int AW    = 32;
  localparam int CW    = 128;
  localparam int LAT   = 5;
  localparam int DEPTH = 1024;
  localparam int POOL  = 64;

`ifdef MAIN_MEMORY_RANGE_CHECK_EN
  localparam bit RANGE_EN = 1'b1;
`else
  localparam bit RANGE_EN = 1'b0;
`endif

  localparam int MODE_DONE  = 0;
  localparam int MODE_ABORT = 1;
  localparam int MODE_RESET = 2;

  typedef struct {
    logic [CW-1:0] data;
    logic          err;
    int            accept;
    int            hold;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   errors;
  int   checks;

  main_memory_if #(.ADDRESS_WIDTH(AW), .CACHE_LINE_WIDTH(CW)) bus_if ();

  main_memory #(
    .ADDRESS_WIDTH(AW),
    .CACHE_LINE_WIDTH(CW),
    .MEM_LATENCY(LAT),
    .MEM_DEPTH_LINES(DEPTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus_if)
  );

  exp_t          sb[$];
  logic [CW-1:0] ref_mem [int];
  logic [CW-1:0] last_read;
  logic [AW-1:0] last_scramble_addr;
  int            valid_rises;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [CW-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Mostly in-pool addresses; occasionally with upper bits set, which still
  // wrap back onto a pool line when range checking is off.
  function automatic logic [AW-1:0] pick_addr();
    logic [AW-1:0] line;
    logic [AW-1:0] off;
    logic [AW-1:0] upper;
    line  = AW'($urandom_range(0, POOL - 1));
    off   = AW'($urandom_range(0, 15));
    upper = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(1, 15)) : '0;
    return (upper << 14) | (line << 4) | off;
  endfunction

  task automatic scramble();
    last_scramble_addr = pick_addr();
    bus_if.mem_addr  = last_scramble_addr;
    bus_if.mem_data  = rand_line();
    bus_if.mem_write = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 64; i++) begin
      if (!bus_if.mem_busy && !bus_if.mem_resp_valid) return;
      @(negedge clk);
    end
    check_output("idle_timeout", 1, 0);
  endtask

  task automatic apply_stimulus(input bit wr, input logic [AW-1:0] addr, input logic [CW-1:0] data,
                                input int hold, input int mode, input int abort_k);
    exp_t e;
    int   line;
    int   idx;
    bit   oor;
    bit   got;
    int   rises_before;

    wait_idle();
    line = int'(addr >> 4);
    idx  = line % DEPTH;
    oor  = RANGE_EN && (line >= DEPTH);

    bus_if.mem_req   = 1'b1;
    bus_if.mem_write = wr;
    bus_if.mem_addr  = addr;
    bus_if.mem_data  = data;
    rises_before     = valid_rises;

    if (mode == MODE_DONE) begin
      e.accept = cyc + 1;
      e.hold   = hold;
      e.err    = oor;
      if (wr) begin
        if (!oor) ref_mem[idx] = data;
        e.data = last_read;
      end else begin
        e.data    = oor ? '0 : ref_mem[idx];
        last_read = e.data;
      end
      sb.push_back(e);

      got = 1'b0;
      for (int i = 0; i < 4 * LAT + 20; i++) begin
        @(negedge clk);
        if (bus_if.mem_resp_valid) begin
          got = 1'b1;
          break;
        end
        scramble();
      end
      if (!got) begin
        check_output("resp_timeout", 0, 1);
        void'(sb.pop_back());
        bus_if.mem_req = 1'b0;
        return;
      end
      repeat (hold) begin
        @(negedge clk);
        scramble();
      end
      bus_if.mem_req = 1'b0;
    end else if (mode == MODE_ABORT) begin
      repeat (abort_k + 1) begin
        @(negedge clk);
        scramble();
      end
      bus_if.mem_req = 1'b0;
      @(negedge clk);
      wait_idle();
      repeat (2) @(negedge clk);
      check_output("abort_no_valid", 32'(valid_rises), 32'(rises_before));
    end else begin
      repeat (2) begin
        @(negedge clk);
        scramble();
      end
      #2 reset = 1'b0;
      #1;
      check_output("rst_valid", bus_if.mem_resp_valid, 0);
      check_output("rst_data",  bus_if.mem_resp_data, 0);
      check_output("rst_busy",  bus_if.mem_busy, 0);
      check_output("rst_err",   bus_if.mem_err, 0);
      bus_if.mem_req = 1'b0;
      last_read      = '0;
      @(negedge clk);
      reset = 1'b1;
    end
  endtask

  // Monitor: compare each response at its first valid cycle against the
  // oldest expectation, then check how long valid stayed up.
  initial begin
    exp_t cur;
    bit   have_cur;
    bit   prev_valid;
    int   run_len;
    have_cur   = 1'b0;
    prev_valid = 1'b0;
    run_len    = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_valid = 1'b0;
        have_cur   = 1'b0;
      end else begin
        if (bus_if.mem_resp_valid && !prev_valid) begin
          valid_rises++;
          check_output("expected_pending", (sb.size() > 0), 1);
          if (sb.size() > 0) begin
            cur      = sb.pop_front();
            have_cur = 1'b1;
            run_len  = 1;
            // valid is raised by the LAT-th edge after the accepting edge,
            // so the arbiter first sees it on edge accept+LAT+1
            check_output("latency",   32'(cyc - cur.accept), 32'(LAT));
            check_output("resp_data", bus_if.mem_resp_data, cur.data);
            check_output("resp_err",  bus_if.mem_err, cur.err);
            check_output("busy_resp", bus_if.mem_busy, 1);
          end
        end else if (bus_if.mem_resp_valid) begin
          run_len++;
        end else if (prev_valid && have_cur) begin
          check_output("valid_len", 32'(run_len), 32'(cur.hold + 1));
          check_output("busy_after_resp", bus_if.mem_busy, 0);
          have_cur = 1'b0;
        end
        prev_valid = bus_if.mem_resp_valid;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL global_timeout: got timeout, expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [CW-1:0] line_data;
    int            r;
    errors      = 0;
    checks      = 0;
    valid_rises = 0;
    last_read   = '0;
    last_scramble_addr = '0;
    bus_if.mem_req   = 1'b0;
    bus_if.mem_write = 1'b0;
    bus_if.mem_addr  = '0;
    bus_if.mem_data  = '0;
    reset = 1'b1;
    #3 reset = 1'b0;
    #1;
    check_output("init_valid", bus_if.mem_resp_valid, 0);
    check_output("init_data",  bus_if.mem_resp_data, 0);
    check_output("init_busy",  bus_if.mem_busy, 0);
    check_output("init_err",   bus_if.mem_err, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    $display("[TB] preloading %0d lines", POOL);
    for (int i = 0; i < POOL; i++) begin
      apply_stimulus(1'b1, AW'(i * 16), rand_line(), $urandom_range(0, 2), MODE_DONE, 0);
    end

    $display("[TB] directed cases");
    line_data = 128'hDEADBEEF_00000001_CAFEF00D_12345678;
    apply_stimulus(1'b1, 32'h0000_0040, line_data, 0, MODE_DONE, 0);
    apply_stimulus(1'b0, 32'h0000_0048, '0, 0, MODE_DONE, 0);
    apply_stimulus(1'b0, 32'h0000_0048, '0, 3, MODE_DONE, 0);
    apply_stimulus(1'b1, 32'h0000_0100, rand_line(), 0, MODE_ABORT, 2);
    apply_stimulus(1'b0, 32'h0000_0100, '0, 1, MODE_DONE, 0);
    apply_stimulus(1'b1, 32'h0000_0300, rand_line(), 0, MODE_RESET, 0);
    apply_stimulus(1'b0, 32'h0000_0300, '0, 0, MODE_DONE, 0);
    apply_stimulus(1'b0, 32'h0001_0000, '0, 0, MODE_DONE, 0);
    apply_stimulus(1'b1, 32'h0000_0200, rand_line(), 0, MODE_DONE, 0);
    apply_stimulus(1'b0, 32'h0000_0200, '0, 0, MODE_DONE, 0);
    apply_stimulus(1'b0, last_scramble_addr, '0, 0, MODE_DONE, 0);

    $display("[TB] random traffic");
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 99);
      if (r < 10) begin
        apply_stimulus(1'($urandom_range(0, 1)), pick_addr(), rand_line(), 0, MODE_ABORT,
                       $urandom_range(0, LAT - 1));
      end else if (r < 13) begin
        apply_stimulus(1'b1, pick_addr(), rand_line(), 0, MODE_RESET, 0);
      end else begin
        apply_stimulus(1'($urandom_range(0, 1)), pick_addr(), rand_line(),
                       $urandom_range(0, 3), MODE_DONE, 0);
      end
    end

    wait_idle();
    repeat (4) @(negedge clk);
    check_output("scoreboard_drained", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/main_memory.md
MAIN_MEMORY -- requirements
Module: main_memory

Interface
REQ-001 SHALL have parameter MEM_LATENCY, default 5, meaning cycles from request acceptance to response (legal range 1..255).
REQ-002 SHALL have parameter MEM_DEPTH_LINES, default 1024, meaning number of CACHE_LINE_WIDTH-bit lines stored (power of two).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port mem_req  input  1  request from the arbiter, held high until the response is consumed.
REQ-006 SHALL have port mem_write  input  1  1 = line write, 0 = line read.
REQ-007 SHALL have port mem_addr  input  ADDRESS_WIDTH  byte address from the arbiter.
REQ-008 SHALL have port mem_data  input  CACHE_LINE_WIDTH  write line data.
REQ-009 SHALL have port mem_resp_valid  output  1  transaction complete; read data valid.
REQ-010 SHALL have port mem_resp_data  output  CACHE_LINE_WIDTH  read line data.
REQ-011 SHALL have port mem_busy  output  1  high in any state other than IDLE.
REQ-012 SHALL have port mem_err  output  1  out-of-range access flag, qualified by mem_resp_valid.

Function
REQ-013 SHALL implement an FSM with the states IDLE, BUSY and RESP.
REQ-014 In IDLE with mem_req=1, the block SHALL latch mem_write, the line index and mem_data, load the counter with MEM_LATENCY-1, and enter BUSY.
REQ-015 Line index SHALL be mem_addr[OFF+log2(MEM_DEPTH_LINES)-1:OFF], with OFF = log2(CACHE_LINE_WIDTH/8); byte-offset bits are ignored.
REQ-016 Changes on mem_write, mem_addr or mem_data after acceptance SHALL be ignored until the block returns to IDLE.
REQ-017 In BUSY the counter SHALL decrement each cycle; when it reaches 0 the block SHALL perform the array access and enter RESP.
REQ-018 For a write, the array access SHALL store the latched data. For a read, it SHALL register the line into mem_resp_data.
REQ-019 The first cycle of mem_resp_valid=1 SHALL be exactly MEM_LATENCY+1 cycles after the accepting edge.
REQ-020 In RESP, mem_resp_valid SHALL stay 1 while mem_req=1; on the first cycle with mem_req=0 the block SHALL go to IDLE and mem_resp_valid SHALL drop at that edge.
REQ-021 A new request SHALL NOT be accepted in the same cycle the block leaves RESP; the minimum gap between transactions is one IDLE cycle.
REQ-022 If mem_req falls while in BUSY, the transaction SHALL abort: no array write, no mem_resp_valid, return to IDLE.
REQ-023 mem_resp_data SHALL hold its last value except when a read completes; after a write it SHALL be unchanged.
REQ-024 A read following a write to the same line SHALL return the newly written data.

Reset
REQ-025 Assertion of reset (low) SHALL immediately force state=IDLE, counter=0, mem_resp_valid=0, mem_resp_data=0, mem_err=0, mem_busy=0.
REQ-026 Reset asserted mid-transaction SHALL abort the transaction with no array write; array contents SHALL NOT be reset.
REQ-027 Deassertion of reset SHALL be taken synchronously to clk; the first request can be accepted on the first edge after deassertion.

Configuration
REQ-028 Macro MAIN_MEMORY_RANGE_CHECK_EN SHALL control out-of-range detection.
REQ-029 When defined: an access with (mem_addr >> OFF) >= MEM_DEPTH_LINES SHALL not write the array. A read of such an address SHALL return all-zero data. mem_err=1 SHALL accompany mem_resp_valid.
REQ-030 When undefined: the upper address bits SHALL be ignored (the index wraps modulo MEM_DEPTH_LINES), and mem_err SHALL be tied to 0.

Verification (ADDRESS_WIDTH=32, CACHE_LINE_WIDTH=128, MEM_LATENCY=5, MEM_DEPTH_LINES=1024)
REQ-031 Write 0xDEADBEEF_00000001_CAFEF00D_12345678 to 0x0000_0040, then read 0x0000_0048 -> identical line, mem_resp_valid first high 6 cycles after each accept.
REQ-032 Read with mem_req held 3 cycles after mem_resp_valid -> mem_resp_valid high exactly those 3 cycles plus the first; IDLE one cycle later; no second transaction.
REQ-033 Write to 0x100, mem_req dropped 2 cycles after accept, then read 0x100 -> old contents returned; no mem_resp_valid for the aborted write.
REQ-034 Reset pulsed low during BUSY of a write -> outputs zero immediately; a following read of that line returns the pre-write data.
REQ-035 With MAIN_MEMORY_RANGE_CHECK_EN, read 0x0001_0000 -> mem_resp_data=0, mem_err=1. Without it, the same read returns line 0 contents and mem_err=0.
REQ-036 Change mem_addr and mem_data while in BUSY of a write to 0x200 -> only 0x200 updated, with the originally latched data.
